// File: rtl/machine_timer_unit_pkg.sv
// Shared types and constants for the machine timer (mtime/mtimecmp) unit.
package TimerTypes;

    localparam int unsigned TIMER_REG_ADDR_WIDTH = 3;

    typedef logic [TIMER_REG_ADDR_WIDTH-1:0] TimerRegAddrPath;
    typedef logic [63:0]                     TimerCountPath;

    // Word offsets on the register port; 6 and 7 are unmapped.
    typedef enum logic [TIMER_REG_ADDR_WIDTH-1:0] {
        TIMER_REG_MTIME_LO    = 3'd0,
        TIMER_REG_MTIME_HI    = 3'd1,
        TIMER_REG_CMP_LO      = 3'd2,
        TIMER_REG_CMP_HI      = 3'd3,
        TIMER_REG_CTRL        = 3'd4,
        TIMER_REG_HI_SNAPSHOT = 3'd5
    } TimerRegAddr;

    localparam int unsigned   TIMER_CTRL_ENABLE_BIT = 0;
    localparam TimerCountPath TIMER_CMP_RESET_VALUE = '1;

endpackage

// File: rtl/machine_timer_unit_prescaler.sv
// Prescaler: divides the core clock by PRESCALE_DIV into a one-cycle mtime tick.
module timer_prescaler #(
    parameter int unsigned PRESCALE_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = enable && (count == CW'(PRESCALE_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/machine_timer_unit.sv
// RISC-V machine timer: register port, prescaled 64-bit mtime, mtimecmp compare.
module machine_timer_unit
    import TimerTypes::*;
#(
    parameter int unsigned PRESCALE_DIV         = 1,
    parameter int unsigned TIMER_ADDR_BIT_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            reqValid,
    input  logic                            reqWE,
    input  logic [TIMER_ADDR_BIT_WIDTH-1:0] reqAddr,
    input  logic [31:0]                     reqWriteData,
    output logic                            respValid,
    output logic [31:0]                     respReadData,
    output logic                            reqTimerInterrupt,
    output logic [63:0]                     mtimeOut
);

    TimerCountPath mtime;
    TimerCountPath mtime_next;
    TimerCountPath mtimecmp;
    logic          ctrl_enable;
    logic [31:0]   snapshot;
    logic [31:0]   read_mux;
    logic          tick;

    logic sel_mtime_lo, sel_mtime_hi, sel_cmp_lo, sel_cmp_hi, sel_ctrl, sel_snapshot;
    logic wr, rd;

    assign sel_mtime_lo = (reqAddr == TIMER_ADDR_BIT_WIDTH'(TIMER_REG_MTIME_LO));
    assign sel_mtime_hi = (reqAddr == TIMER_ADDR_BIT_WIDTH'(TIMER_REG_MTIME_HI));
    assign sel_cmp_lo   = (reqAddr == TIMER_ADDR_BIT_WIDTH'(TIMER_REG_CMP_LO));
    assign sel_cmp_hi   = (reqAddr == TIMER_ADDR_BIT_WIDTH'(TIMER_REG_CMP_HI));
    assign sel_ctrl     = (reqAddr == TIMER_ADDR_BIT_WIDTH'(TIMER_REG_CTRL));
    assign sel_snapshot = (reqAddr == TIMER_ADDR_BIT_WIDTH'(TIMER_REG_HI_SNAPSHOT));

    assign wr = reqValid && reqWE;
    assign rd = reqValid && !reqWE;

    timer_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .enable(ctrl_enable),
        .clear (wr && (sel_mtime_lo || sel_mtime_hi)),
        .tick  (tick)
    );

    // Software writes take priority over the tick so a written value is never bumped.
    always_comb begin
        mtime_next = mtime;
        if (wr && sel_mtime_lo) begin
            mtime_next = {mtime[63:32], reqWriteData};
        end else if (wr && sel_mtime_hi) begin
            mtime_next = {reqWriteData, mtime[31:0]};
        end else if (tick) begin
            mtime_next = mtime + 64'd1;
        end
    end

    always_comb begin
        read_mux = '0;
        if (sel_mtime_lo) read_mux = mtime[31:0];
        if (sel_mtime_hi) read_mux = mtime[63:32];
        if (sel_cmp_lo)   read_mux = mtimecmp[31:0];
        if (sel_cmp_hi)   read_mux = mtimecmp[63:32];
        if (sel_ctrl)     read_mux = {31'd0, ctrl_enable};
        if (sel_snapshot) read_mux = snapshot;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime       <= '0;
            mtimecmp    <= TIMER_CMP_RESET_VALUE;
            ctrl_enable <= 1'b1;
        end else begin
            mtime <= mtime_next;
            if (wr && sel_cmp_lo) mtimecmp[31:0]  <= reqWriteData;
            if (wr && sel_cmp_hi) mtimecmp[63:32] <= reqWriteData;
            if (wr && sel_ctrl)   ctrl_enable     <= reqWriteData[TIMER_CTRL_ENABLE_BIT];
        end
    end

    // Reading mtime_lo latches the high half so a later snapshot read is torn-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snapshot     <= '0;
            respValid    <= 1'b0;
            respReadData <= '0;
        end else begin
            respValid <= reqValid;
            if (reqValid) begin
                respReadData <= reqWE ? '0 : read_mux;
            end
            if (rd && sel_mtime_lo) begin
                snapshot <= mtime[63:32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reqTimerInterrupt <= 1'b0;
        end else begin
            reqTimerInterrupt <= (mtime >= mtimecmp);
        end
    end

    assign mtimeOut = mtime;

endmodule

// File: tb/tb_machine_timer_unit.sv
// Directed bench: PRESCALE_DIV=1 and PRESCALE_DIV=4 instances share clock and reset.
module tb_machine_timer_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        v1 = 1'b0, we1 = 1'b0;
    logic [2:0]  a1 = '0;
    logic [31:0] d1 = '0;
    logic        rv1, irq1;
    logic [31:0] rd1;
    logic [63:0] mt1;

    logic        v4 = 1'b0, we4 = 1'b0;
    logic [2:0]  a4 = '0;
    logic [31:0] d4 = '0;
    logic        rv4, irq4;
    logic [31:0] rd4;
    logic [63:0] mt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    machine_timer_unit #(.PRESCALE_DIV(1), .TIMER_ADDR_BIT_WIDTH(3)) u_dut1 (
        .clk(clk), .rst(rst), .reqValid(v1), .reqWE(we1), .reqAddr(a1),
        .reqWriteData(d1), .respValid(rv1), .respReadData(rd1),
        .reqTimerInterrupt(irq1), .mtimeOut(mt1)
    );

    machine_timer_unit #(.PRESCALE_DIV(4), .TIMER_ADDR_BIT_WIDTH(3)) u_dut4 (
        .clk(clk), .rst(rst), .reqValid(v4), .reqWE(we4), .reqAddr(a4),
        .reqWriteData(d4), .respValid(rv4), .respReadData(rd4),
        .reqTimerInterrupt(irq4), .mtimeOut(mt4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus1(input logic [2:0] a, input logic we, input logic [31:0] d);
        v1 = 1'b1; we1 = we; a1 = a; d1 = d;
        step();
        v1 = 1'b0; we1 = 1'b0;
    endtask

    task automatic bus4(input logic [2:0] a, input logic we, input logic [31:0] d);
        v4 = 1'b1; we4 = we; a4 = a; d4 = d;
        step();
        v4 = 1'b0; we4 = 1'b0;
    endtask

    initial begin
        step(); step();
        chk("rst_mtime",   mt1, 64'd0);
        chk("rst_irq",     {63'd0, irq1}, 64'd0);
        chk("rst_rv",      {63'd0, rv1}, 64'd0);
        chk("rst_rdata",   {32'd0, rd1}, 64'd0);
        chk("rst_mtime4",  mt4, 64'd0);
        rst = 1'b1;

        repeat (10) step();
        chk("count10", mt1, 64'd10);
        v1 = 1'b1; we1 = 1'b0; a1 = 3'd0;
        chk("rv_not_early", {63'd0, rv1}, 64'd0);
        step();
        v1 = 1'b0;
        chk("rv_one_cycle", {63'd0, rv1}, 64'd1);
        chk("read_lo10", {32'd0, rd1}, 64'd10);
        step();
        chk("rv_drops", {63'd0, rv1}, 64'd0);
        chk("rdata_holds", {32'd0, rd1}, 64'd10);

        bus1(3'd0, 1'b1, 32'd0);
        chk("mtime_lo_wr", mt1, 64'd0);
        chk("wr_resp_zero", {32'd0, rd1}, 64'd0);
        bus1(3'd3, 1'b1, 32'd0);
        bus1(3'd2, 1'b1, 32'd20);
        chk("mtime_after_cmp_wr", mt1, 64'd2);
        repeat (18) step();
        chk("mtime_eq_cmp", mt1, 64'd20);
        chk("irq_not_yet", {63'd0, irq1}, 64'd0);
        step();
        chk("irq_rise", {63'd0, irq1}, 64'd1);
        repeat (5) step();
        chk("irq_level", {63'd0, irq1}, 64'd1);
        bus1(3'd2, 1'b1, 32'd1000);
        chk("irq_still_after_cmp_wr", {63'd0, irq1}, 64'd1);
        step();
        chk("irq_drop_cmp_raise", {63'd0, irq1}, 64'd0);

        bus1(3'd2, 1'b1, 32'd5);
        bus1(3'd1, 1'b1, 32'd0);
        bus1(3'd0, 1'b1, 32'hFFFF_FFFE);
        bus1(3'd1, 1'b1, 32'hFFFF_FFFF);
        chk("mtime_near_wrap", mt1, 64'hFFFF_FFFF_FFFF_FFFE);
        step(); step();
        chk("mtime_wrapped", mt1, 64'd0);
        chk("irq_at_wrap", {63'd0, irq1}, 64'd1);
        step();
        chk("irq_after_wrap", {63'd0, irq1}, 64'd0);

        bus1(3'd2, 1'b0, 32'd0);
        chk("read_cmp_lo", {32'd0, rd1}, 64'd5);
        bus1(3'd3, 1'b0, 32'd0);
        chk("read_cmp_hi", {32'd0, rd1}, 64'd0);
        bus1(3'd4, 1'b0, 32'd0);
        chk("read_ctrl", {32'd0, rd1}, 64'd1);
        bus1(3'd6, 1'b0, 32'd0);
        chk("read_unmapped", {32'd0, rd1}, 64'd0);
        bus1(3'd5, 1'b1, 32'h1234);
        bus1(3'd5, 1'b0, 32'd0);
        chk("snapshot_wr_ignored", {32'd0, rd1}, 64'd0);

        bus1(3'd1, 1'b1, 32'd1);
        bus1(3'd0, 1'b1, 32'hFFFF_FFFF);
        chk("torn_setup", mt1, 64'h0000_0001_FFFF_FFFF);
        bus1(3'd0, 1'b0, 32'd0);
        chk("torn_lo", {32'd0, rd1}, 64'hFFFF_FFFF);
        bus1(3'd5, 1'b0, 32'd0);
        chk("torn_snapshot", {32'd0, rd1}, 64'd1);
        chk("torn_mtime", mt1, 64'h0000_0002_0000_0001);
        bus1(3'd1, 1'b0, 32'd0);
        chk("live_hi", {32'd0, rd1}, 64'd2);

        bus1(3'd4, 1'b1, 32'd0);
        chk("disable_last_tick", mt1, 64'h0000_0002_0000_0003);
        repeat (20) step();
        chk("frozen", mt1, 64'h0000_0002_0000_0003);
        bus1(3'd4, 1'b0, 32'd0);
        chk("read_ctrl_off", {32'd0, rd1}, 64'd0);

        v1 = 1'b1; we1 = 1'b0; a1 = 3'd1;
        step();
        chk("rv_before_rst", {63'd0, rv1}, 64'd1);
        #2;
        rst = 1'b0;
        v1 = 1'b0;
        #1;
        chk("rst_async_rv", {63'd0, rv1}, 64'd0);
        chk("rst_async_rdata", {32'd0, rd1}, 64'd0);
        chk("rst_async_mtime", mt1, 64'd0);
        chk("rst_async_irq", {63'd0, irq1}, 64'd0);
        rst = 1'b1;

        repeat (3) step();
        chk("p4_no_tick_yet", mt4, 64'd0);
        bus4(3'd0, 1'b1, 32'h100);
        chk("p4_collision", mt4, 64'h100);
        repeat (3) step();
        chk("p4_hold", mt4, 64'h100);
        step();
        chk("p4_next_inc", mt4, 64'h101);
        repeat (2) step();
        bus4(3'd0, 1'b1, 32'h200);
        repeat (3) step();
        chk("p4_clear_hold", mt4, 64'h200);
        step();
        chk("p4_clear_inc", mt4, 64'h201);
        chk("p4_irq", {63'd0, irq4}, 64'd0);

        chk("post_rst_rv", {63'd0, rv1}, 64'd0);
        bus1(3'd3, 1'b0, 32'd0);
        chk("post_rst_cmp_hi", {32'd0, rd1}, 64'hFFFF_FFFF);
        bus1(3'd2, 1'b0, 32'd0);
        chk("post_rst_cmp_lo", {32'd0, rd1}, 64'hFFFF_FFFF);
        bus1(3'd4, 1'b0, 32'd0);
        chk("post_rst_ctrl", {32'd0, rd1}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
